if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the control unit.
- Owns the PC register and issues word-aligned requests to an instruction memory with variable latency and in-order responses.
- Buffers returned instructions in a small in-order queue and presents the head instruction, its PC and pre-split decode fields (opcode, funct3, funct7, register indices) over a valid/ready handshake.
- Accepts a redirect from branch/jump resolution; a redirect flushes all in-flight and buffered work.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, number of queue entries; also the maximum number of outstanding requests. Legal range 1..8.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  32  request address, bits [1:0] always 0.
- imem_rsp_valid  input  1  response valid; responses return in request order.
- imem_rsp_data  input  32  instruction word.
- redirect_valid  input  1  load a new fetch PC and flush.
- redirect_pc  input  32  new PC; bits [1:0] ignored (treated as 0).
- inst_valid  output  1  head instruction available.
- inst_ready  input  1  downstream consumes the head instruction.
- inst  output  32  head instruction word.
- inst_pc  output  32  PC of the head instruction.
- opcode  output  7  inst[6:0].
- funct3  output  3  inst[14:12].
- funct7  output  7  inst[31:25].
- rd  output  5  inst[11:7].
- rs1  output  5  inst[19:15].
- rs2  output  5  inst[24:20].

Behaviour:

Reset (async assert, sync-released use):
- fetch_pc = RESET_PC.
- Queue empty, drop_cnt = 0.
- imem_req_valid = 0, inst_valid = 0, all data outputs = 0.

Queue entries:
- Each entry holds {pc, data, filled}, managed as a circular buffer with head/tail pointers and an occupancy count.
- An entry is allocated at request acceptance, filled on response, and freed on pop.
- Pointers wrap modulo DEPTH.

Request issue:
- imem_req_valid = !redirect_valid && (occupancy + drop_cnt < DEPTH).
- imem_req_addr = fetch_pc.
- On acceptance (imem_req_valid && imem_req_ready), in the same edge:
  - Allocate the tail entry with pc = fetch_pc, filled = 0.
  - fetch_pc += 4 (32-bit wrap: 32'hFFFF_FFFC -> 0).
- imem_req_valid may drop without acceptance; the address must not change while valid is held, except via redirect.

Response:
- If drop_cnt > 0: decrement drop_cnt, discard the data.
- Otherwise: write data into the oldest unfilled entry and set filled.
- A response while no request is outstanding is a protocol error; the stage ignores it.

Output:
- inst_valid = head entry filled.
- inst and inst_pc come from the head entry; decode fields are combinational slices of inst.
- Pop on inst_valid && inst_ready.
- Latency: a response captured at edge N gives inst_valid = 1 after edge N (registered); no combinational path from imem_rsp_* to inst_*.

Redirect (redirect_valid = 1 at edge N):
- fetch_pc = {redirect_pc[31:2], 2'b00}.
- The queue is cleared.
- drop_cnt = (drop_cnt + unfilled allocated entries) minus 1 if a response arrives at edge N.
- No request is issued in cycle N.
- Redirect takes priority over simultaneous pop, fill and allocate. A handshake completed in cycle N counts as consumed downstream, but its entry is discarded anyway.

Concurrency and boundaries:
- Allocate, fill and pop may all occur in one cycle; occupancy += alloc − pop.
- Full (occupancy + drop_cnt == DEPTH): no request until a pop or a drop.
- Empty: inst_valid = 0; inst, inst_pc and fields hold their last values.
- drop_cnt width is $clog2(DEPTH+1) and never exceeds DEPTH.
- Reset asserted mid-operation clears everything immediately. The memory must be reset alongside; pre-reset responses are not tracked.

Test Plan:
1. Reset release, memory with 0-cycle ready and 1-cycle response, inst_ready = 1 -> requests at 0x0, 0x4, 0x8…; inst_pc follows; add x1,x2,x3 (0x003100B3) gives opcode 0x33, rd 1, rs1 2, rs2 3, funct7 0.
2. inst_ready held 0 with DEPTH = 2 -> exactly 2 requests accepted, imem_req_valid then 0; release ready -> pops in order 0x0, 0x4 and fetch resumes at 0x8.
3. Redirect to 0x103 with 2 outstanding requests (response latency 3) -> fetch restarts at 0x100, both stale responses are dropped, first inst_pc = 0x100.
4. Redirect in the same cycle as a response and a pop -> response discarded, drop_cnt = outstanding − 1, queue empty next cycle, no request that cycle.
5. redirect_pc = 0xFFFF_FFFC -> requests at 0xFFFF_FFFC then 0x0000_0000.
6. Assert rst_n low mid-burst with the queue full -> inst_valid and imem_req_valid drop immediately; after release the next request is at RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, issues in-order memory requests and queues returned words for decode.
// Latency: a response captured at edge N is presented after edge N. Backpressure: requests stop while queued plus dropped entries reach DEPTH.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic             r_run;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_pc   [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_filled;
  logic [PW-1:0]    r_head, r_tail, r_fptr;
  logic [CW-1:0]    r_count, r_unfilled, r_drop;
  logic [31:0]      r_inst, r_inst_pc;

  logic [CW-1:0]    w_occ, w_redir_drop;
  logic             w_alloc, w_rsp, w_fill, w_drop_rsp, w_pop, w_sub;
  logic [PW-1:0]    w_nhead;
  logic             w_fill_nhead, w_nload;
  logic [31:0]      w_ndata;
  logic [1:0]       w_unused_bits;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign w_occ          = r_count + r_drop;
  assign imem_req_valid = r_run && !redirect_valid && (w_occ < CW'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_alloc        = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding are ignored rather than corrupting state.
  assign w_rsp      = imem_rsp_valid && r_run;
  assign w_drop_rsp = w_rsp && (r_drop != '0);
  assign w_fill     = w_rsp && (r_drop == '0) && (r_unfilled != '0);
  assign w_sub      = w_rsp && ((r_drop != '0) || (r_unfilled != '0));
  assign w_redir_drop = r_drop + r_unfilled - CW'(w_sub);

  assign inst_valid = r_filled[r_head];
  assign w_pop      = inst_valid && inst_ready;

  // Output registers track the next head so the outputs hold once the queue empties.
  assign w_nhead      = w_pop ? f_inc(r_head) : r_head;
  assign w_fill_nhead = w_fill && (r_fptr == w_nhead);
  assign w_nload      = (r_filled[w_nhead] && !(w_pop && (w_nhead == r_head))) || w_fill_nhead;
  assign w_ndata      = w_fill_nhead ? imem_rsp_data : r_data[w_nhead];

  assign w_unused_bits = redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_filled   <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_fptr     <= '0;
      r_count    <= '0;
      r_unfilled <= '0;
      r_drop     <= '0;
      r_inst     <= '0;
      r_inst_pc  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_run <= 1'b1;
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
        r_filled   <= '0;
        r_head     <= '0;
        r_tail     <= '0;
        r_fptr     <= '0;
        r_count    <= '0;
        r_unfilled <= '0;
        r_drop     <= w_redir_drop;
      end else begin
        if (w_alloc) begin
          r_pc[r_tail]     <= r_fetch_pc;
          r_filled[r_tail] <= 1'b0;
          r_tail           <= f_inc(r_tail);
          r_fetch_pc       <= r_fetch_pc + 32'd4;
        end
        if (w_fill) begin
          r_data[r_fptr]   <= imem_rsp_data;
          r_filled[r_fptr] <= 1'b1;
          r_fptr           <= f_inc(r_fptr);
        end
        if (w_pop) begin
          r_filled[r_head] <= 1'b0;
          r_head           <= f_inc(r_head);
        end
        if (w_drop_rsp) r_drop <= r_drop - 1'b1;
        r_count    <= r_count + CW'(w_alloc) - CW'(w_pop);
        r_unfilled <= r_unfilled + CW'(w_alloc) - CW'(w_fill);
        if (w_nload) begin
          r_inst    <= w_ndata;
          r_inst_pc <= r_pc[w_nhead];
        end
      end
    end
  end

  assign inst    = r_inst;
  assign inst_pc = r_inst_pc;
  assign opcode  = r_inst[6:0];
  assign rd      = r_inst[11:7];
  assign funct3  = r_inst[14:12];
  assign rs1     = r_inst[19:15];
  assign rs2     = r_inst[24:20];
  assign funct7  = r_inst[31:25];
endmodule
